// File: rtl/rgb_pkg.sv
// Shared definitions for consumers of the 3-bit RGB traffic-light bus:
// light codes, colour indices, sequence order and checker states.
package rgb_pkg;

    typedef logic [1:0] color_t;

    localparam logic [0:2] LIGHT_RED    = 3'b100;
    localparam logic [0:2] LIGHT_GREEN  = 3'b010;
    localparam logic [0:2] LIGHT_YELLOW = 3'b001;

    localparam color_t COL_NONE = 2'd0;
    localparam color_t COL_GRN  = 2'd1;
    localparam color_t COL_YEL  = 2'd2;
    localparam color_t COL_RED  = 2'd3;

    // State encodings deliberately equal the colour index of the tracked colour.
    typedef enum logic [1:0] {
        ST_ACQ = 2'd0,
        ST_GRN = 2'd1,
        ST_YEL = 2'd2,
        ST_RED = 2'd3
    } state_e;

    function automatic color_t next_color(input color_t c);
        case (c)
            COL_GRN: next_color = COL_YEL;
            COL_YEL: next_color = COL_RED;
            COL_RED: next_color = COL_GRN;
            default: next_color = COL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rgb_seq_checker_if.sv
// Light-bus sample inputs and status outputs of the RGB sequence checker.
interface rgb_seq_checker_if
    import rgb_pkg::*;
#(
    parameter int CYC_W = 16
);
    logic             en;
    logic [0:2]       light;
    logic             clr_err;
    color_t           cur_color;
    logic             locked;
    logic [CYC_W-1:0] cycle_count;
    logic             err_code;
    logic             err_order;
    logic             err_short;
    logic             err_long;
    logic             err_any;

    modport master (
        output en, light, clr_err,
        input  cur_color, locked, cycle_count,
        input  err_code, err_order, err_short, err_long, err_any
    );

    modport slave (
        input  en, light, clr_err,
        output cur_color, locked, cycle_count,
        output err_code, err_order, err_short, err_long, err_any
    );

endinterface

// File: rtl/rgb_light_decode.sv
// Combinational decode of a light code into a colour index; anything that
// is not exactly one-hot is flagged illegal.
module rgb_light_decode
    import rgb_pkg::*;
(
    input  logic [0:2] light,
    output color_t     color,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        color   = COL_NONE;
        illegal = 1'b0;
        case (light)
            LIGHT_RED:    color   = COL_RED;
            LIGHT_GREEN:  color   = COL_GRN;
            LIGHT_YELLOW: color   = COL_YEL;
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rgb_seq_checker.sv
// Monitors the RGB light bus: locks onto Green->Yellow->Red, checks dwell
// time per colour, counts completed cycles and keeps sticky error flags.
module rgb_seq_checker
    import rgb_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 2,
    parameter int CNT_W     = 8,
    parameter int CYC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    rgb_seq_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    color_t           color_q;
    logic             locked_q;
    logic             err_code_q, err_order_q, err_short_q, err_long_q, err_any_q;
    logic             set_code, set_order, set_short, set_long;
    logic             err_code_d, err_order_d, err_short_d, err_long_d;

    color_t smp_color;
    logic   smp_illegal;
    color_t trk_color;

    rgb_light_decode u_decode (
        .light   (bus.light),
        .color   (smp_color),
        .illegal (smp_illegal)
    );

    assign trk_color = color_t'(state_q);

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        cycle_d   = cycle_q;
        set_code  = 1'b0;
        set_order = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        if (bus.en) begin
            if (state_q == ST_ACQ) begin
                if (smp_illegal) begin
                    set_code = 1'b1;
                end else if (smp_color == COL_GRN) begin
                    state_d = ST_GRN;
                    dwell_d = DWELL_ONE;
                end
            end else if (smp_illegal) begin
                set_code = 1'b1;
                state_d  = ST_ACQ;
                dwell_d  = '0;
            end else if (smp_color == trk_color) begin
                if (dwell_q != '1) dwell_d = dwell_q + DWELL_ONE;
                // Flag only on the sample that first exceeds the limit.
                if (dwell_q == DWELL_MAX) set_long = 1'b1;
            end else if (smp_color == next_color(trk_color)) begin
                if (dwell_q < DWELL_MIN) set_short = 1'b1;
                state_d = state_e'(smp_color);
                dwell_d = DWELL_ONE;
                if (trk_color == COL_RED) cycle_d = cycle_q + CYC_W'(1);
            end else begin
                set_order = 1'b1;
                state_d   = ST_ACQ;
                dwell_d   = '0;
            end
        end
    end

    // A new error in the same cycle as clr_err must still leave the flag set.
    always_comb begin
        err_code_d  = (err_code_q  & ~bus.clr_err) | set_code;
        err_order_d = (err_order_q & ~bus.clr_err) | set_order;
        err_short_d = (err_short_q & ~bus.clr_err) | set_short;
        err_long_d  = (err_long_q  & ~bus.clr_err) | set_long;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACQ;
            dwell_q     <= '0;
            cycle_q     <= '0;
            color_q     <= COL_NONE;
            locked_q    <= 1'b0;
            err_code_q  <= 1'b0;
            err_order_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_any_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            cycle_q     <= cycle_d;
            color_q     <= color_t'(state_d);
            locked_q    <= (state_d != ST_ACQ);
            err_code_q  <= err_code_d;
            err_order_q <= err_order_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_any_q   <= err_code_d | err_order_d | err_short_d | err_long_d;
        end
    end

    assign bus.cur_color   = color_q;
    assign bus.locked      = locked_q;
    assign bus.cycle_count = cycle_q;
    assign bus.err_code    = err_code_q;
    assign bus.err_order   = err_order_q;
    assign bus.err_short   = err_short_q;
    assign bus.err_long    = err_long_q;
    assign bus.err_any     = err_any_q;

endmodule

// File: doc/rgb_seq_checker.md
Name: rgb_seq_checker

Overview:
- Receive-side monitor for the 3-bit RGB traffic-light code driven by the light sequencer.
- Decodes the light code, locks onto the Green→Yellow→Red→Green order and checks per-colour dwell time.
- Counts completed light cycles and raises sticky error flags.
- Used on the light bus in simulation and on-board as a health checker.

Parameters:
- MIN_DWELL, 1: minimum consecutive samples per colour before the next colour is legal.
- MAX_DWELL, 2: maximum consecutive samples per colour before dwell-long error.
- CNT_W, 8: dwell counter width. Counter saturates at 2^CNT_W-1. MAX_DWELL must be < 2^CNT_W-1.
- CYC_W, 16: cycle counter width. Counter wraps.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- en  input  1  sample enable; light is sampled only when en=1.
- light  input  [0:2]  light code, same bit ordering as the sequencer output: red=3'b100, green=3'b010, yellow=3'b001.
- clr_err  input  1  synchronous clear of all sticky error flags.
- cur_color  output  2  tracked colour: 0=none, 1=green, 2=yellow, 3=red.
- locked  output  1  checker is tracking a valid sequence.
- cycle_count  output  CYC_W  count of completed Red→Green transitions.
- err_code  output  1  sticky: illegal light code seen.
- err_order  output  1  sticky: out-of-order colour seen.
- err_short  output  1  sticky: colour left before MIN_DWELL samples.
- err_long  output  1  sticky: colour held more than MAX_DWELL samples.
- err_any  output  1  OR of the four error flags.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state ACQ, dwell counter 0.
  - cur_color=0, locked=0, cycle_count=0, all error flags 0.
  - rst dominates en and clr_err.
- Timing:
  - All outputs are registered.
  - The effect of a sample taken at posedge N is visible after posedge N.
  - en=0: no state, counter or flag changes; clr_err is still honoured.
- Decode: a code is legal only if it is one of the three one-hot values. 000, 011, 101, 110 and 111 are illegal.
- State ACQ (locked=0, cur_color=0):
  - Legal green → GRN, dwell=1, locked=1.
  - Legal yellow or red → ignored, remain in ACQ.
  - Illegal code → set err_code, remain in ACQ.
- States GRN, YEL, RED (locked=1, cur_color=1/2/3). For current colour X with dwell counter d:
  - Sample == X → d=d+1 (saturating). When d+1 == MAX_DWELL+1, set err_long. Remain in X; lock is kept.
  - Sample == next(X), where next = G→Y→R→G:
    - If d < MIN_DWELL, set err_short.
    - Move to next(X), d=1.
    - On RED→GRN, cycle_count increments (wraps at 2^CYC_W).
  - Sample is another legal colour (skip or backwards) → set err_order; go to ACQ, locked=0, d=0.
  - Illegal code → set err_code; go to ACQ, locked=0, d=0.
- Error flags:
  - Sticky until clr_err.
  - If clr_err and a new error-set condition occur in the same cycle, the new error wins (flag reads 1).
  - cycle_count is not cleared by clr_err.
- Reset mid-operation: next cycle returns to the reset values, regardless of state.
- With the defaults, the sequencer's normal output (green held 2 samples after its reset, then 1 sample per colour) produces no errors.

Decomposition:
- Shared package rgb_pkg:
  - Light code constants RED/GREEN/YELLOW.
  - 2-bit colour index constants NONE/GRN/YEL/RED.
  - next_color function.
  - Checker state enum ACQ/GRN/YEL/RED.
- One natural sub-module, rgb_light_decode: combinational; light[0:2] → colour index plus illegal flag. Reusable by other light-bus consumers.
- Dwell and cycle counters, the FSM and the error flags stay in rgb_seq_checker.

Test Plan:
- Reset, then drive (en=1) G,G,Y,R,G,Y,R,G → locked=1 after the first G; cur_color follows 1,1,2,3,1,2,3,1; cycle_count=2; err_any=0 throughout.
- Locked in YEL, drive 3'b110 → next cycle err_code=1, locked=0, cur_color=0. Then pulse clr_err → err_code=0. Then drive G → relock.
- Locked in GRN, drive R → err_order=1, locked=0, cycle_count unchanged. Later, clr_err and an illegal code 3'b000 in the same cycle → err_code=1.
- Defaults: drive G×3 then Y → err_long=1 after the 3rd G, locked stays 1, cur_color=2 after Y.
- MIN_DWELL=2: drive G×2, Y×1, R → err_short=1 on the Y→R step; cur_color=3, still locked.
- Mid-stream: en=0 for 5 cycles with a changing light → outputs frozen. Then assert rst with cycle_count=5 → next cycle cycle_count=0, locked=0, flags 0.
